pll_nco_multi: RTL and testbench
================================

# pll_nco_multi

Parametrised multi-channel clock generator that replaces the single-output simulation PLL with a synthesisable numerically controlled oscillator (NCO) bank. It runs from the board input clock and produces, per channel, a 50 %-duty square-wave clock and a one-cycle sample strobe at a runtime-programmable rate (e.g. 44.1 kHz audio frame rate). It also drives a `locked` flag gated by a settle timer. It sits at the top of the audio datapath and feeds the codec serialiser and sample FIFOs.

## Interface
- `NUM_CH`, 2, number of independent NCO channels (1–8)
- `ACC_W`, 24, phase-accumulator width in bits
- `LOCK_CYCLES`, 256, settle time in `inclk0` cycles before `locked` asserts (≥1)
- `INC_RESET`, 14798, per-channel increment loaded at reset (44.1 kHz from 50 MHz at `ACC_W`=24)

- `inclk0`  in  1  sole clock; all logic on its rising edge
- `areset_n`  in  1  asynchronous, active-low reset
- `ena`  in  1  run enable; low forces IDLE
- `cfg_we`  in  1  single-cycle increment write strobe
- `cfg_ch`  in  $clog2(NUM_CH) (min 1)  target channel of the write
- `cfg_inc`  in  ACC_W  new phase increment
- `c`  out  NUM_CH  per-channel square-wave clock (accumulator MSB)
- `stb`  out  NUM_CH  per-channel one-cycle pulse on accumulator wrap
- `locked`  out  1  high once configuration has been stable and running for `LOCK_CYCLES`

## Operation
- Reset (async, `areset_n`=0): FSM=IDLE, all accumulators 0, all increments `INC_RESET`, settle counter 0, `c`=0, `stb`=0, `locked`=0.
- FSM states: IDLE, SETTLE, LOCKED.
  - IDLE: accumulators held at 0, `c`/`stb`/`locked` 0. `ena`=1 -> SETTLE with counter cleared.
  - SETTLE: accumulators run; counter increments each cycle; counter = `LOCK_CYCLES`-1 -> LOCKED.
  - LOCKED: accumulators run; `locked`=1.
  - Any state, `ena`=0 -> IDLE (takes priority over `cfg_we`).
  - SETTLE or LOCKED, valid `cfg_we` -> SETTLE with counter cleared; `locked` drops the next cycle.
- Accumulator per channel: acc <= (acc + inc) mod 2^ACC_W. `stb` = registered carry-out of that add. `c` = acc[ACC_W-1]. Output frequency = f_inclk0 · inc / 2^ACC_W.
- Config write (`cfg_we`=1, `cfg_ch` < `NUM_CH`): the increment register of that channel takes `cfg_inc`, and its accumulator clears to 0 on the same edge. Other channels are undisturbed. Writes are accepted in IDLE: the increment is stored with no FSM change.
- `cfg_ch` ≥ `NUM_CH`: write ignored entirely, with no lock drop.
- `cfg_inc`=0: channel frozen at acc=0, so `c`=0 and `stb` never fires.
- `cfg_inc` ≥ 2^(ACC_W-1): legal. Aliased output; `stb` may be high on consecutive cycles.

## Timing
- `ena` sampled high at edge k: SETTLE from k; `locked` high from edge k+`LOCK_CYCLES`.
- First accumulator update occurs at edge k+1 after entry to SETTLE (acc is 0 at edge k).
- `stb` is high for exactly the cycle following the wrapping add, coincident with `c` 1->0.
- Config write at edge k: new increment used from the add at edge k+1.
- `ena` low at edge k: all outputs 0 after edge k.
- `areset_n` assertion mid-run clears all outputs immediately (asynchronously). Deassertion is synchronised externally; no outputs change until the first edge after release.

## Structure
- Package `pll_nco_pkg`: FSM state enum (IDLE/SETTLE/LOCKED), the `INC_RESET` default constant, and a constant function `nco_inc(f_out, f_clk, acc_w)` returning round(f_out·2^acc_w/f_clk) for testbench and top-level use.
- Sub-module `nco_channel`: one accumulator, increment register, and carry/`stb`/`c` logic. Instantiated `NUM_CH` times by a generate loop. FSM and settle counter live in the top module.

## Test plan
- Reset then `ena`=1, `LOCK_CYCLES`=16 -> `locked`=0 for 15 cycles and 1 on the 16th edge; `c`/`stb`=0 throughout reset.
- `ACC_W`=8, write inc=64 to ch0 -> `stb` every 4 cycles; `c` pattern 0,0,1,1 repeating; ch1 unaffected.
- `ACC_W`=24, 50 MHz clock, default inc 14798 -> 44100 ± 1 `stb` pulses per 50 000 000 cycles.
- While LOCKED, write ch1 inc=0 -> `locked` low next cycle and relocks after `LOCK_CYCLES`; ch1 `c`=0 with no `stb`.
- Write with `cfg_ch`=`NUM_CH` while LOCKED -> no increment change, `locked` stays 1. Write in IDLE -> stored, used after `ena`.
- Drop `ena` mid-period, or pulse `areset_n` low mid-period -> all outputs 0 immediately (reset) or next edge (`ena`); restart produces a phase from acc=0.

Source files
------------

// File: rtl/pll_nco_pkg.sv
// Shared types and helpers for the multi-channel NCO clock generator.
// nco_inc() converts a target frequency into a phase increment.
package pll_nco_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  // 44.1 kHz from a 50 MHz clock with a 24-bit accumulator
  localparam int NCO_INC_RESET = 14798;

  function automatic longint nco_inc(input longint f_out, input longint f_clk, input int acc_w);
    return ((f_out << acc_w) + (f_clk / 2)) / f_clk;
  endfunction

endpackage

// File: rtl/pll_nco_multi_channel.sv
// One NCO channel: phase accumulator, increment register, wrap strobe.
// A write restarts the phase from zero so the new rate starts cleanly.
module nco_channel
  import pll_nco_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int INC_RESET = NCO_INC_RESET
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             we,
  input  logic [ACC_W-1:0] wr_inc,
  output logic             c,
  output logic             stb
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] inc_reg;
  logic             stb_reg;
  logic [ACC_W:0]   sum_next;

  // Extra top bit is the carry-out that becomes the strobe.
  assign sum_next = {1'b0, acc_reg} + {1'b0, inc_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      inc_reg <= ACC_W'(INC_RESET);
      stb_reg <= 1'b0;
    end else begin
      if (we) begin
        inc_reg <= wr_inc;
      end
      if (!run || we) begin
        acc_reg <= '0;
        stb_reg <= 1'b0;
      end else begin
        acc_reg <= sum_next[ACC_W-1:0];
        stb_reg <= sum_next[ACC_W];
      end
    end
  end

  assign c   = acc_reg[ACC_W-1];
  assign stb = stb_reg;

endmodule

// File: rtl/pll_nco_multi.sv
// Multi-channel NCO clock generator with a settle timer gating 'locked'.
// Any accepted reconfiguration restarts the settle period.
module pll_nco_multi
  import pll_nco_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 256,
  parameter int INC_RESET   = NCO_INC_RESET,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              inclk0,
  input  logic              areset_n,
  input  logic              ena,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [NUM_CH-1:0] c,
  output logic [NUM_CH-1:0] stb,
  output logic              locked
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      cfg_ch_ext;
  logic             cfg_valid;
  logic             run;

  // Widened so the range check stays meaningful when NUM_CH is a power of two.
  assign cfg_ch_ext = 32'(cfg_ch);
  assign cfg_valid  = cfg_we && (cfg_ch_ext < 32'(NUM_CH));
  assign run        = ena && (state_reg != ST_IDLE);
  assign locked     = (state_reg == ST_LOCKED);

  always_ff @(posedge inclk0 or negedge areset_n) begin
    if (!areset_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ena) begin
          state_next = ST_SETTLE;
          cnt_next   = '0;
        end
      end
      ST_SETTLE: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(LOCK_CYCLES - 1)) begin
          state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: ;
      default: state_next = ST_IDLE;
    endcase
    if (state_reg != ST_IDLE && cfg_valid) begin
      state_next = ST_SETTLE;
      cnt_next   = '0;
    end
    // Disable overrides everything, including a same-cycle write.
    if (!ena) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    nco_channel #(
      .ACC_W     (ACC_W),
      .INC_RESET (INC_RESET)
    ) u_ch (
      .clk    (inclk0),
      .rst_n  (areset_n),
      .run    (run),
      .we     (cfg_valid && (cfg_ch_ext == 32'(gi))),
      .wr_inc (cfg_inc),
      .c      (c[gi]),
      .stb    (stb[gi])
    );
  end

endmodule

// File: tb/tb_pll_nco_multi.sv
// Directed bench for pll_nco_multi: 3 channels, 8-bit accumulators, 16-cycle settle.
// Expected waveforms come from closed-form phase = adds * inc mod 2^ACC_W.
module tb_pll_nco_multi;
  import pll_nco_pkg::*;

  localparam int NUM_CH = 3;
  localparam int ACC_W  = 8;
  localparam int LOCK   = 16;
  localparam int INC_R  = 32;
  localparam int MOD    = 1 << ACC_W;

  logic              inclk0 = 1'b0;
  logic              areset_n;
  logic              ena;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic [NUM_CH-1:0] c;
  logic [NUM_CH-1:0] stb;
  logic              locked;

  int errors = 0;
  int checks = 0;

  // Expected-state bookkeeping: adds since phase restart, increment, settle edges.
  int m_cnt [NUM_CH];
  int m_inc [NUM_CH];
  int since;
  bit running;

  pll_nco_multi #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK),
    .INC_RESET   (INC_R)
  ) dut (
    .inclk0   (inclk0),
    .areset_n (areset_n),
    .ena      (ena),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .c        (c),
    .stb      (stb),
    .locked   (locked)
  );

  always #5 inclk0 = ~inclk0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_c(input int m, input int inc);
    return ((m * inc) % MOD) / (MOD / 2);
  endfunction

  function automatic int exp_stb(input int m, input int inc);
    if (m == 0) return 0;
    return (((m * inc) / MOD) != (((m - 1) * inc) / MOD)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    running = 1'b0;
    since   = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_cnt[ch] = 0;
      m_inc[ch] = INC_R;
    end
  endtask

  // Advance expectations for the coming edge, take the edge, then compare.
  task automatic step(input string tag);
    bit wr_ok;
    wr_ok = cfg_we && (int'(cfg_ch) < NUM_CH);
    if (!ena) begin
      running = 1'b0;
      since   = 0;
      for (int ch = 0; ch < NUM_CH; ch++) m_cnt[ch] = 0;
      if (wr_ok) m_inc[int'(cfg_ch)] = int'(cfg_inc);
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (wr_ok && int'(cfg_ch) == ch) begin
          m_inc[ch] = int'(cfg_inc);
          m_cnt[ch] = 0;
        end else if (running) begin
          m_cnt[ch]++;
        end
      end
      if (!running) begin
        running = 1'b1;
        since   = 0;
      end else if (wr_ok) begin
        since = 0;
      end else begin
        since++;
      end
    end
    @(posedge inclk0);
    #1;
    check({tag, " locked"}, 32'(locked), 32'((running && since >= LOCK) ? 1 : 0));
    for (int ch = 0; ch < NUM_CH; ch++) begin
      check($sformatf("%s c%0d", tag, ch), 32'(c[ch]), 32'(exp_c(m_cnt[ch], m_inc[ch])));
      check($sformatf("%s stb%0d", tag, ch), 32'(stb[ch]), 32'(exp_stb(m_cnt[ch], m_inc[ch])));
    end
  endtask

  task automatic run_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step($sformatf("%s[%0d]", tag, i));
  endtask

  task automatic cfg_write(input int ch, input int inc, input string tag);
    cfg_we  = 1'b1;
    cfg_ch  = 2'(ch);
    cfg_inc = ACC_W'(inc);
    step(tag);
    cfg_we  = 1'b0;
    $display("cfg write ch=%0d inc=%0d ena=%0b locked=%0b", ch, inc, ena, locked);
  endtask

  initial begin
    areset_n = 1'b0;
    ena      = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_inc  = '0;
    model_reset();

    repeat (3) @(posedge inclk0);
    #1;
    check("rst c", 32'(c), 32'd0);
    check("rst stb", 32'(stb), 32'd0);
    check("rst locked", 32'(locked), 32'd0);
    check("nco_inc 44k1", 32'(nco_inc(44100, 50000000, 24)), 32'd14798);
    check("nco_inc quarter", 32'(nco_inc(1, 4, 8)), 32'd64);

    areset_n = 1'b1;
    ena      = 1'b1;
    $display("enable from reset");
    run_steps(22, "settle");

    cfg_write(0, 64, "wr ch0");
    run_steps(20, "ch0 inc64");

    cfg_write(1, 0, "wr ch1");
    run_steps(20, "ch1 inc0");

    cfg_write(3, 200, "wr bad ch");
    run_steps(6, "after bad");

    ena = 1'b0;
    $display("disable mid-period");
    step("ena off");
    cfg_write(2, 96, "idle wr ch2");
    step("idle");
    ena = 1'b1;
    $display("re-enable");
    run_steps(20, "ch2 inc96");

    #2;
    areset_n = 1'b0;
    #1;
    $display("async reset mid-period");
    check("areset c", 32'(c), 32'd0);
    check("areset stb", 32'(stb), 32'd0);
    check("areset locked", 32'(locked), 32'd0);
    model_reset();
    @(posedge inclk0);
    #1;
    check("areset hold c", 32'(c), 32'd0);
    areset_n = 1'b1;
    run_steps(12, "post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
